adc_conversion_sequencer: RTL and testbench
===========================================

# adc_conversion_sequencer

Sequences conversions of the 4-comparator opamp-ladder flash ADC and turns its raw thermometer outputs into timed, averaged, validated results. Sits in the digital domain between the ladder's asynchronous comparator outputs and the chip's digital outputs. It synchronizes a start request, waits for the ladder to settle, and accumulates popcounts over a sample window. It then reports a rounded 3-bit level (0–4) with a valid pulse and a bubble-error flag, in either single-shot or continuous mode.

## Interface
Parameters:
- SETTLE_CYCLES, 16, cycles spent in SETTLE before sampling; legal range 1..255.
- LOG2_SAMPLES, 2, log2 of samples per conversion (window = 2^LOG2_SAMPLES); legal range 0..4.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  raw asynchronous request (push-button); rising edge starts a conversion.
- continuous  in  1  level; when high at RESOLVE, the sequencer re-enters SAMPLE instead of IDLE.
- thermo_in  in  4  asynchronous comparator outputs; bit 0 has the lowest threshold.
- code  out  3  registered result, 0..4; holds until the next result.
- code_valid  out  1  one-cycle pulse when `code` updates.
- bubble_err  out  1  registered with `code`; 1 if any sample in that window was non-thermometer.
- busy  out  1  high whenever state != IDLE.
- state_out  out  2  current state: IDLE=0, SETTLE=1, SAMPLE=2, RESOLVE=3.

## Operation
- Synchronization:
  - `start` passes through 2 flops (s1, s2) plus a delay flop d; start_edge = s2 & ~d.
  - `thermo_in` passes through 2 flops per bit. All decisions use synchronized values only.
- IDLE:
  - Accumulator and counters are cleared.
  - start_edge moves to SETTLE, with the settle counter loaded to SETTLE_CYCLES-1.
- SETTLE:
  - The counter decrements each cycle.
  - At 0, load the sample counter to 2^LOG2_SAMPLES-1, clear the accumulator and bubble flag, and go to SAMPLE.
- SAMPLE, each cycle:
  - acc += popcount(thermo_sync).
  - bubble_acc |= (thermo_sync not in {0000, 0001, 0011, 0111, 1111}).
  - The sample counter decrements; at 0, go to RESOLVE.
- RESOLVE, 1 cycle:
  - Next code = min(4, (acc + rnd) >> LOG2_SAMPLES), with rnd = 2^(LOG2_SAMPLES-1), or 0 when LOG2_SAMPLES = 0.
  - code, bubble_err and a code_valid pulse are registered on the exit edge.
  - Next state is SAMPLE if `continuous` = 1 (sample counter reloaded, accumulator and bubble flag cleared, no re-settle). Otherwise IDLE.
- Arithmetic widths:
  - Accumulator is 3+LOG2_SAMPLES bits and cannot overflow (max 4·2^LOG2_SAMPLES).
  - Rounding add is done at accumulator width + 1.
- Boundary conditions:
  - start_edge while busy is dropped; it is not queued.
  - `continuous` falling mid-window: the current window completes, one result is reported, then IDLE.
  - `start` held high produces exactly one start_edge.
  - reset at any point, including mid-SAMPLE:
    - Next cycle: state IDLE, code=0, code_valid=0, bubble_err=0, busy=0, state_out=0.
    - All sync flops, counters and the accumulator are cleared.
    - No partial result is emitted.

## Timing
- Reset values: code=0, code_valid=0, bubble_err=0, busy=0, state_out=0.
- Latency, single shot:
  - Take the first clk edge that samples `start` high as edge 0.
  - Start-edge detect → state=SETTLE after edge 2.
  - SAMPLE begins after edge 2+SETTLE_CYCLES.
  - RESOLVE after edge 2+SETTLE_CYCLES+2^LOG2_SAMPLES.
  - code/code_valid after edge 3+SETTLE_CYCLES+2^LOG2_SAMPLES, which is 23 with defaults.
- `thermo_in` must be stable from 2 cycles before SAMPLE starts to count in the first sample.
- Continuous mode: code_valid repeats every 2^LOG2_SAMPLES+1 cycles (5 with defaults).
- busy rises with state=SETTLE and falls in the cycle code_valid is high (single shot).

## Test plan
- Defaults, thermo_in=0011 constant, start pulse → code_valid exactly 23 cycles after edge 0, code=2, bubble_err=0, busy high for cycles 3..23, then IDLE.
- Sample sequence 0111,0111,0111,0011 (acc=11) → code=(11+2)>>2=3. Sequence 0111,0111,0001,0001 (acc=8) → code=2. All 1111 → code=4.
- thermo_in=0101 for one sample of the window, 0011 otherwise → bubble_err=1 with that result, and the next clean conversion reports bubble_err=0.
- continuous=1, thermo_in=1111 → code_valid pulses at cycles 23, 28, 33 with code=4. Drop continuous during the window ending at 33 → result at 33, then IDLE, busy=0.
- A second start pulse during SETTLE, and start held high for 100 cycles → exactly one code_valid per start rise after IDLE.
- reset asserted 2 cycles into SAMPLE → next cycle state_out=0, code=0, no code_valid. A fresh start then yields a result 23 cycles later.

Source files
------------

// File: rtl/adc_conversion_sequencer.sv
// Conversion sequencer for the 4-comparator flash ADC: synchronizes start and
// comparator outputs, settles, averages a sample window and reports a rounded level.
module adc_conversion_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int LOG2_SAMPLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic [3:0] thermo_in,
    output logic [2:0] code,
    output logic       code_valid,
    output logic       bubble_err,
    output logic       busy,
    output logic [1:0] state_out
);

    localparam int ACC_W  = 3 + LOG2_SAMPLES;
    localparam int SCNT_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;

    localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SAMPLE_LOAD = SCNT_W'((1 << LOG2_SAMPLES) - 1);
    // Half an LSB of the averaged result; collapses to zero for a one-sample window.
    localparam logic [ACC_W:0]    RND         = (ACC_W + 1)'((1 << LOG2_SAMPLES) >> 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        SAMPLE  = 2'd2,
        RESOLVE = 2'd3
    } state_t;

    state_t state, state_n;

    logic              start_s1, start_s2, start_d;
    logic              start_edge;
    logic [3:0]        thermo_s1, thermo_s2;

    logic [7:0]        settle_cnt, settle_cnt_n;
    logic [SCNT_W-1:0] sample_cnt, sample_cnt_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic              bubble_acc, bubble_acc_n;

    logic [2:0]        code_n;
    logic              bubble_err_n;
    logic              code_valid_n;

    function automatic logic [2:0] popcount4(input logic [3:0] t);
        return 3'(t[0]) + 3'(t[1]) + 3'(t[2]) + 3'(t[3]);
    endfunction

    function automatic logic is_thermometer(input logic [3:0] t);
        return (t == 4'b0000) || (t == 4'b0001) || (t == 4'b0011) ||
               (t == 4'b0111) || (t == 4'b1111);
    endfunction

    // Rounded mean of the window, clamped to the top ladder level.
    function automatic logic [2:0] round_code(input logic [ACC_W-1:0] a);
        logic [ACC_W:0] sum;
        logic [ACC_W:0] mean;
        sum  = {1'b0, a} + RND;
        mean = sum >> LOG2_SAMPLES;
        if (mean > (ACC_W + 1)'(4)) begin
            return 3'd4;
        end
        return mean[2:0];
    endfunction

    assign start_edge = start_s2 & ~start_d;

    // Synchronizer stage: two flops on every asynchronous input plus edge-detect delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_s1  <= 1'b0;
            start_s2  <= 1'b0;
            start_d   <= 1'b0;
            thermo_s1 <= 4'b0000;
            thermo_s2 <= 4'b0000;
        end else begin
            start_s1  <= start;
            start_s2  <= start_s1;
            start_d   <= start_s2;
            thermo_s1 <= thermo_in;
            thermo_s2 <= thermo_s1;
        end
    end

    // Sequencer state, window accumulation and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            bubble_acc <= 1'b0;
            code       <= 3'd0;
            bubble_err <= 1'b0;
            code_valid <= 1'b0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_cnt_n;
            sample_cnt <= sample_cnt_n;
            acc        <= acc_n;
            bubble_acc <= bubble_acc_n;
            code       <= code_n;
            bubble_err <= bubble_err_n;
            code_valid <= code_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        sample_cnt_n = sample_cnt;
        acc_n        = acc;
        bubble_acc_n = bubble_acc;
        code_n       = code;
        bubble_err_n = bubble_err;
        code_valid_n = 1'b0;

        unique case (state)
            IDLE: begin
                settle_cnt_n = '0;
                sample_cnt_n = '0;
                acc_n        = '0;
                bubble_acc_n = 1'b0;
                if (start_edge) begin
                    state_n      = SETTLE;
                    settle_cnt_n = SETTLE_LOAD;
                end
            end

            SETTLE: begin
                if (settle_cnt == 8'd0) begin
                    state_n      = SAMPLE;
                    sample_cnt_n = SAMPLE_LOAD;
                    acc_n        = '0;
                    bubble_acc_n = 1'b0;
                end else begin
                    settle_cnt_n = settle_cnt - 8'd1;
                end
            end

            SAMPLE: begin
                acc_n        = acc + ACC_W'(popcount4(thermo_s2));
                bubble_acc_n = bubble_acc | ~is_thermometer(thermo_s2);
                if (sample_cnt == '0) begin
                    state_n = RESOLVE;
                end else begin
                    sample_cnt_n = sample_cnt - 1'b1;
                end
            end

            RESOLVE: begin
                code_n       = round_code(acc);
                bubble_err_n = bubble_acc;
                code_valid_n = 1'b1;
                // Continuous mode restarts the window directly; the ladder is already settled.
                if (continuous) begin
                    state_n      = SAMPLE;
                    sample_cnt_n = SAMPLE_LOAD;
                    acc_n        = '0;
                    bubble_acc_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_out = state;

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Directed bench for adc_conversion_sequencer with default parameters.
module tb_adc_conversion_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       continuous;
    logic [3:0] thermo_in;
    logic [2:0] code;
    logic       code_valid;
    logic       bubble_err;
    logic       busy;
    logic [1:0] state_out;

    int tests = 0;
    int fails = 0;

    logic       busy_log [64];
    logic [1:0] st_log   [64];

    adc_conversion_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .thermo_in  (thermo_in),
        .code       (code),
        .code_valid (code_valid),
        .bubble_err (bubble_err),
        .busy       (busy),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One single-shot conversion; sample j of the window sees value s<j>.
    // lat is the edge index (edge 0 = first edge sampling start high) of code_valid.
    task automatic conv(input logic [3:0] s0, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [3:0] s3,
                        output int lat, output logic [2:0] c, output logic b);
        lat = -1;
        c   = 3'd0;
        b   = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        thermo_in = s0;
        for (int e = 0; e < 64; e++) begin
            @(posedge clk); #1;
            if (e == 0) start = 1'b0;
            case (e)
                17: thermo_in = s1;
                18: thermo_in = s2;
                19: thermo_in = s3;
                default: ;
            endcase
            busy_log[e] = busy;
            st_log[e]   = state_out;
            if (code_valid && lat < 0) begin
                lat = e;
                c   = code;
                b   = bubble_err;
            end
            if (lat >= 0 && e >= lat + 2) break;
        end
    endtask

    initial begin
        int         lat;
        logic [2:0] c;
        logic       b;
        int         nv;
        int         v_e [8];

        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        thermo_in  = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", code, 0);
        chk("rst_valid", code_valid, 0);
        chk("rst_bubble", bubble_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state_out, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Baseline latency and busy/state timeline
        conv(4'b0011, 4'b0011, 4'b0011, 4'b0011, lat, c, b);
        chk("lat_default", lat, 23);
        chk("code_0011", c, 2);
        chk("bub_0011", b, 0);
        chk("busy_e1", busy_log[1], 0);
        chk("busy_e2", busy_log[2], 1);
        chk("busy_e22", busy_log[22], 1);
        chk("busy_e23", busy_log[23], 0);
        chk("state_e2", st_log[2], 1);
        chk("state_e17", st_log[17], 1);
        chk("state_e18", st_log[18], 2);
        chk("state_e22", st_log[22], 3);
        chk("state_e23", st_log[23], 0);
        repeat (3) @(posedge clk);

        // Rounding patterns
        conv(4'b0111, 4'b0111, 4'b0111, 4'b0011, lat, c, b);
        chk("lat_acc11", lat, 23);
        chk("code_acc11", c, 3);
        conv(4'b0111, 4'b0111, 4'b0001, 4'b0001, lat, c, b);
        chk("code_acc8", c, 2);
        conv(4'b1111, 4'b1111, 4'b1111, 4'b1111, lat, c, b);
        chk("code_full", c, 4);
        conv(4'b0000, 4'b0000, 4'b0000, 4'b0001, lat, c, b);
        chk("code_acc1", c, 0);

        // Bubble detection and clearing
        conv(4'b0011, 4'b0101, 4'b0011, 4'b0011, lat, c, b);
        chk("bub_set", b, 1);
        chk("bub_code", c, 2);
        conv(4'b0011, 4'b0011, 4'b0011, 4'b0011, lat, c, b);
        chk("bub_clear", b, 0);

        // Continuous mode, dropped during the window resolving at edge 33
        continuous = 1'b1;
        thermo_in  = 4'b1111;
        nv = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int e = 0; e < 46; e++) begin
            @(posedge clk); #1;
            if (e == 0) start = 1'b0;
            if (e == 29) continuous = 1'b0;
            if (code_valid) begin
                if (nv < 8) v_e[nv] = e;
                nv++;
                chk("cont_code", code, 4);
            end
            if (e == 34) begin
                chk("cont_busy_after", busy, 0);
                chk("cont_state_after", state_out, 0);
            end
        end
        chk("cont_count", nv, 3);
        chk("cont_v0", v_e[0], 23);
        chk("cont_v1", v_e[1], 28);
        chk("cont_v2", v_e[2], 33);

        // Second start during SETTLE is dropped
        thermo_in = 4'b0011;
        nv = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            if (e == 0) start = 1'b0;
            if (e == 5) start = 1'b1;
            if (e == 6) start = 1'b0;
            if (code_valid) begin
                if (nv < 8) v_e[nv] = e;
                nv++;
            end
        end
        chk("restart_count", nv, 1);
        chk("restart_lat", v_e[0], 23);

        // Start held high for 100 cycles gives one conversion
        nv = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int e = 0; e < 120; e++) begin
            @(posedge clk); #1;
            if (e == 99) start = 1'b0;
            if (code_valid) begin
                if (nv < 8) v_e[nv] = e;
                nv++;
            end
        end
        chk("held_count", nv, 1);
        chk("held_lat", v_e[0], 23);
        conv(4'b0111, 4'b0111, 4'b0111, 4'b0111, lat, c, b);
        chk("after_held_lat", lat, 23);
        chk("after_held_code", c, 3);

        // Reset two cycles into SAMPLE
        nv = 0;
        thermo_in = 4'b1111;
        @(posedge clk); #1;
        start = 1'b1;
        for (int e = 0; e < 21; e++) begin
            @(posedge clk); #1;
            if (e == 0) start = 1'b0;
        end
        chk("pre_reset_state", state_out, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_state", state_out, 0);
        chk("mid_rst_code", code, 0);
        chk("mid_rst_valid", code_valid, 0);
        chk("mid_rst_busy", busy, 0);
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (code_valid) nv++;
        end
        chk("mid_rst_no_result", nv, 0);
        conv(4'b0001, 4'b0001, 4'b0001, 4'b0001, lat, c, b);
        chk("post_rst_lat", lat, 23);
        chk("post_rst_code", c, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
